// File: rtl/lfsr_stream_checker.sv
// Receive-side checker for the 20-bit panel test-pattern LFSR stream.
// Self-synchronises, tracks lock with a flywheel, and keeps match/error/wrap statistics.
module lfsr_stream_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             In_valid,
  input  logic [19:0]      In_data,
  input  logic             Clear,
  output logic             Locked,
  output logic             Err_pulse,
  output logic [CNT_W-1:0] Match_count,
  output logic [CNT_W-1:0] Err_count,
  output logic [CNT_W-1:0] Wrap_count,
  output logic [19:0]      Expected
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  // Zero is the only lockup state of the recurrence; it maps to 1.
  function automatic logic [19:0] lfsr_next(input logic [19:0] x);
    if (x == 20'd0) return 20'd1;
    return {x[18:0], 1'b0} ^ (x & 20'd359);
  endfunction

  state_t      state, state_nxt;
  logic [3:0]  run, run_nxt;
  logic [3:0]  miss, miss_nxt;
  logic [19:0] exp_nxt;
  logic        hit;
  logic        err_nxt;
  logic        match_ev, wrap_ev, err_ev;

  always_comb begin
    state_nxt = state;
    run_nxt   = run;
    miss_nxt  = miss;
    exp_nxt   = Expected;
    err_nxt   = 1'b0;
    match_ev  = 1'b0;
    wrap_ev   = 1'b0;
    err_ev    = 1'b0;
    hit       = (In_data == Expected);
    if (In_valid) begin
      case (state)
        HUNT: begin
          exp_nxt   = lfsr_next(In_data);
          run_nxt   = 4'd0;
          state_nxt = VERIFY;
        end
        VERIFY: begin
          // Both outcomes reseed from the received word; a miss restarts the run.
          exp_nxt = lfsr_next(In_data);
          if (hit) begin
            run_nxt = run + 4'd1;
            if ((run + 4'd1) == LOCK_N) begin
              state_nxt = LOCKED;
              miss_nxt  = 4'd0;
            end
          end else begin
            run_nxt = 4'd0;
          end
        end
        LOCKED: begin
          // Flywheel: prediction advances from our own sequence, never from the input.
          exp_nxt = lfsr_next(Expected);
          if (hit) begin
            match_ev = 1'b1;
            wrap_ev  = In_data[19];
            miss_nxt = 4'd0;
          end else begin
            err_ev   = 1'b1;
            err_nxt  = 1'b1;
            miss_nxt = miss + 4'd1;
            if ((miss + 4'd1) == LOSS_N) state_nxt = HUNT;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= HUNT;
      run       <= 4'd0;
      miss      <= 4'd0;
      Expected  <= 20'd0;
      Locked    <= 1'b0;
      Err_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      run       <= run_nxt;
      miss      <= miss_nxt;
      Expected  <= exp_nxt;
      Locked    <= (state_nxt == LOCKED);
      Err_pulse <= err_nxt;
    end
  end

  // Clear beats a same-cycle event; the error counter sticks at all-ones.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Match_count <= '0;
      Err_count   <= '0;
      Wrap_count  <= '0;
    end else if (Clear) begin
      Match_count <= '0;
      Err_count   <= '0;
      Wrap_count  <= '0;
    end else begin
      if (match_ev) Match_count <= Match_count + CNT_ONE;
      if (wrap_ev)  Wrap_count  <= Wrap_count + CNT_ONE;
      if (err_ev && (Err_count != '1)) Err_count <= Err_count + CNT_ONE;
    end
  end

endmodule

// File: doc/lfsr_stream_checker.md
# lfsr_stream_checker

Receive-side companion to the panel test pattern generator. It consumes the 20-bit pseudo-random word stream produced by the recurrence `next(x) = (x == 0) ? 1 : ((x << 1) ^ (x & 359)) mod 2^20`. It self-synchronises to that stream, tracks lock, and counts matches, errors and bit-19 "wrap" events. All counters and status are exposed as registered outputs so the panel can display them.

## Interface
- LOCK_COUNT, 4: consecutive correct predictions required to declare lock (1..15).
- LOSS_COUNT, 3: consecutive mispredictions in LOCKED that drop lock (1..15).
- CNT_W, 16: width of the statistics counters.
- Clk  in  1  clock; all state changes on its rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- In_valid  in  1  In_data carries a word this cycle.
- In_data  in  20  received stream word.
- Clear  in  1  synchronous clear of Match_count, Err_count and Wrap_count only.
- Locked  out  1  checker is in LOCKED.
- Err_pulse  out  1  one-cycle pulse per mispredicted word while LOCKED.
- Match_count  out  CNT_W  correct words received while LOCKED.
- Err_count  out  CNT_W  mispredicted words received while LOCKED.
- Wrap_count  out  CNT_W  correct LOCKED words with bit 19 set.
- Expected  out  20  current prediction for the next word.

## Operation
- Words are processed only in cycles with In_valid=1. With In_valid=0, state, counters and Err_pulse hold, except that Err_pulse returns to 0.
- Internal registers:
  - state ∈ {HUNT, VERIFY, LOCKED}
  - run: 4 bits, consecutive matches in VERIFY
  - miss: 4 bits, consecutive misses in LOCKED
  - Expected: 20 bits
- HUNT, on a valid word w:
  - Expected ← next(w), run ← 0, go to VERIFY.
- VERIFY, on a valid word w:
  - w == Expected: run ← run+1 and Expected ← next(w). If run+1 == LOCK_COUNT, go to LOCKED with miss ← 0.
  - w ≠ Expected: reseed with Expected ← next(w), run ← 0, stay in VERIFY.
- LOCKED, on a valid word w:
  - w == Expected: Match_count +1, Wrap_count +1 if w[19]=1, miss ← 0, Expected ← next(Expected).
  - w ≠ Expected: Err_count +1, Err_pulse ← 1, miss ← miss+1. The checker keeps predicting from its own sequence, so Expected ← next(Expected), not next(w). If miss+1 == LOSS_COUNT, go to HUNT.
- next() is computed combinationally on 20 bits. The shift discards bit 19, and the operand 0 maps to 1.
- Counter arithmetic:
  - Match_count and Wrap_count wrap modulo 2^CNT_W.
  - Err_count saturates at 2^CNT_W−1.
- Clear in the same cycle as a counted event: Clear wins, the counter becomes 0 and the event is lost.
- Clear does not affect state, run, miss, Expected or Locked.

## Timing
- Reset values: state=HUNT, Locked=0, Err_pulse=0, all counters 0, Expected=0, run=0, miss=0. Reset takes effect immediately and asynchronously, including mid-lock.
- All outputs are registered and update on the Clk edge that samples the valid word, so they are visible one cycle after the word.
- Lock latency: from the first word after reset or loss, Locked rises after 1+LOCK_COUNT consecutive valid, in-sequence words. With the default, that is the edge sampling the 5th word.
- Loss latency: Locked falls on the edge sampling the LOSS_COUNT-th consecutive mispredicted word. That word counts in Err_count and pulses Err_pulse.
- The word that causes the HUNT→VERIFY transition is never counted.
- Back-to-back valid words are accepted every cycle. There is no backpressure.

## Test plan
- Lock: after reset, drive 0,1,3,5,15 on consecutive valid cycles. Locked=0 through the 4th edge and 1 after the 5th edge. Expected=25 and all counters are 0.
- Locked counting: continue 25 and the next 200 words of the true sequence. Match_count=201, Err_count=0, and Wrap_count equals the count of those words with bit19=1 (bench reference model).
- Flywheel single error: while locked, corrupt one word (bit0 flipped) and then resume the true sequence. There is exactly one Err_pulse, Err_count=1, Locked stays 1, and the next true word matches.
- Loss: while locked, drive 3 consecutive words of 0xABCDE. Err_count +3, and Locked falls after the 3rd. A subsequent 5 true words relock.
- VERIFY reseed: from reset, drive 1,3,7 then 1,3,5,15,25. No lock until the edge after 25 (the reseed at 7 restarts run). Err_count stays 0.
- Reset and Clear: assert Rst_n=0 mid-lock, asynchronously between edges. Locked and the counters go to 0 immediately. Separately, pulse Clear coincident with a matching bit-19 word: Match_count and Wrap_count read 0 and Locked is unchanged.
